// File: rtl/sha3_byte_packer.sv
// sha3_byte_packer: packs a valid/ready byte stream into 32-bit words for the
// keccak core. First byte of a word lands in [31:24]. Each message ends with
// a word flagged is_last: either a partial word (byte_num = 1..3) or, when the
// length is a multiple of four, an all-zero terminator with byte_num = 0.
// After the last word, new bytes are blocked until the core reports the digest.
module sha3_byte_packer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_last,
    output logic             byte_ready,
    output logic [31:0]      kc_in,
    output logic             kc_in_ready,
    output logic             kc_is_last,
    output logic [1:0]       kc_byte_num,
    input  logic             kc_buffer_full,
    input  logic             kc_out_ready,
    output logic [LEN_W-1:0] msg_len,
    output logic             busy
);

    typedef enum logic [2:0] {
        FILL        = 3'd0,
        SEND        = 3'd1,
        SEND_LAST   = 3'd2,
        SEND_PAD    = 3'd3,
        WAIT_DIGEST = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q;
    logic [1:0]       cnt_q;
    logic [31:0]      word_q;
    logic             pad_pending_q;
    logic [LEN_W-1:0] msg_len_q;
    logic             kc_in_ready_q;
    logic             kc_is_last_q;
    logic [1:0]       kc_byte_num_q;

    logic             byte_xfer_s;
    logic             word_xfer_s;

    assign byte_ready  = (state_q == FILL);
    assign byte_xfer_s = byte_valid & (state_q == FILL);
    assign word_xfer_s = kc_in_ready_q & ~kc_buffer_full;

    assign kc_in       = word_q;
    assign kc_in_ready = kc_in_ready_q;
    assign kc_is_last  = kc_is_last_q;
    assign kc_byte_num = kc_byte_num_q;
    assign msg_len     = msg_len_q;
    assign busy        = ~((state_q == FILL) && (cnt_q == 2'd0));

    // Packer FSM: byte packing, word handshake, terminator and digest wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FILL;
            cnt_q         <= 2'd0;
            word_q        <= 32'd0;
            pad_pending_q <= 1'b0;
            msg_len_q     <= '0;
            kc_in_ready_q <= 1'b0;
            kc_is_last_q  <= 1'b0;
            kc_byte_num_q <= 2'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (byte_xfer_s) begin
                        case (cnt_q)
                            2'd0:    word_q[31:24] <= byte_in;
                            2'd1:    word_q[23:16] <= byte_in;
                            2'd2:    word_q[15:8]  <= byte_in;
                            default: word_q[7:0]   <= byte_in;
                        endcase
                        if (msg_len_q != LEN_MAX) begin
                            msg_len_q <= msg_len_q + LEN_ONE;
                        end else begin
                            msg_len_q <= msg_len_q;
                        end
                        if (cnt_q == 2'd3) begin
                            // Full word; a last byte here still owes a terminator.
                            state_q       <= SEND;
                            cnt_q         <= 2'd0;
                            pad_pending_q <= byte_last;
                            kc_in_ready_q <= 1'b1;
                            kc_is_last_q  <= 1'b0;
                            kc_byte_num_q <= 2'd0;
                        end else if (byte_last) begin
                            state_q       <= SEND_LAST;
                            cnt_q         <= 2'd0;
                            kc_in_ready_q <= 1'b1;
                            kc_is_last_q  <= 1'b1;
                            kc_byte_num_q <= cnt_q + 2'd1;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else begin
                        state_q <= FILL;
                    end
                end
                SEND: begin
                    if (word_xfer_s) begin
                        word_q <= 32'd0;
                        if (pad_pending_q) begin
                            // Zero terminator follows immediately; ready stays high.
                            state_q       <= SEND_PAD;
                            kc_in_ready_q <= 1'b1;
                            kc_is_last_q  <= 1'b1;
                            kc_byte_num_q <= 2'd0;
                        end else begin
                            state_q       <= FILL;
                            kc_in_ready_q <= 1'b0;
                            kc_is_last_q  <= 1'b0;
                            kc_byte_num_q <= 2'd0;
                        end
                    end else begin
                        state_q <= SEND;
                    end
                end
                SEND_LAST: begin
                    if (word_xfer_s) begin
                        state_q       <= WAIT_DIGEST;
                        word_q        <= 32'd0;
                        kc_in_ready_q <= 1'b0;
                        kc_is_last_q  <= 1'b0;
                        kc_byte_num_q <= 2'd0;
                    end else begin
                        state_q <= SEND_LAST;
                    end
                end
                SEND_PAD: begin
                    if (word_xfer_s) begin
                        state_q       <= WAIT_DIGEST;
                        word_q        <= 32'd0;
                        pad_pending_q <= 1'b0;
                        kc_in_ready_q <= 1'b0;
                        kc_is_last_q  <= 1'b0;
                        kc_byte_num_q <= 2'd0;
                    end else begin
                        state_q <= SEND_PAD;
                    end
                end
                WAIT_DIGEST: begin
                    if (kc_out_ready) begin
                        state_q   <= FILL;
                        msg_len_q <= '0;
                    end else begin
                        state_q <= WAIT_DIGEST;
                    end
                end
                default: begin
                    state_q       <= FILL;
                    cnt_q         <= 2'd0;
                    word_q        <= 32'd0;
                    pad_pending_q <= 1'b0;
                    kc_in_ready_q <= 1'b0;
                    kc_is_last_q  <= 1'b0;
                    kc_byte_num_q <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Testbench for sha3_byte_packer: drives messages with random valid gaps and
// random core backpressure, and compares every transferred word against a
// message-level model of the expected word sequence.
module tb_sha3_byte_packer;

    localparam int LW = 4;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_last = 1'b0;
    logic          byte_ready;
    logic [31:0]   kc_in;
    logic          kc_in_ready;
    logic          kc_is_last;
    logic [1:0]    kc_byte_num;
    logic          kc_buffer_full = 1'b0;
    logic          kc_out_ready = 1'b0;
    logic [LW-1:0] msg_len;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int full_pct = 0;
    int valid_pct = 100;

    logic [7:0] msg[$];
    word_t      exp_q[$];
    word_t      obs_q[$];
    int         xcyc[$];

    sha3_byte_packer #(.LEN_W(LW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_last      (byte_last),
        .byte_ready     (byte_ready),
        .kc_in          (kc_in),
        .kc_in_ready    (kc_in_ready),
        .kc_is_last     (kc_is_last),
        .kc_byte_num    (kc_byte_num),
        .kc_buffer_full (kc_buffer_full),
        .kc_out_ready   (kc_out_ready),
        .msg_len        (msg_len),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic load(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    task automatic load_random(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    // Model: 4-byte chunks, first byte most significant; the final partial
    // chunk is the last word, otherwise a zero terminator closes the message.
    task automatic build_expected();
        int n;
        n = msg.size();
        exp_q.delete();
        for (int i = 0; i < n; i += 4) begin
            int k;
            logic [31:0] w;
            k = (n - i < 4) ? (n - i) : 4;
            w = 32'd0;
            for (int j = 0; j < k; j++) w = w | ({24'd0, msg[i+j]} << (24 - 8*j));
            if (k == 4) exp_q.push_back({w, 1'b0, 2'd0});
            else        exp_q.push_back({w, 1'b1, 2'(k)});
        end
        if (n % 4 == 0) exp_q.push_back({32'd0, 1'b1, 2'd0});
    endtask

    task automatic send_msg(input string name);
        int idx;
        int budget;
        bit pend;
        bit fl;
        word_t pw;
        word_t cur;
        idx = 0; budget = 0; pend = 0; pw = '0;
        build_expected();
        obs_q.delete();
        xcyc.delete();
        while (obs_q.size() < exp_q.size() && budget < 600) begin
            @(negedge clk);
            budget++;
            cur = {kc_in, kc_is_last, kc_byte_num};
            if (pend) begin
                checks++;
                if (kc_in_ready !== 1'b1 || cur !== pw) begin
                    errors++;
                    $display("FAIL %s hold: got rdy=%b w=%h last=%b bn=%0d want rdy=1 w=%h last=%b bn=%0d",
                             name, kc_in_ready, cur.w, cur.last, cur.bn, pw.w, pw.last, pw.bn);
                end
            end
            fl = ($urandom_range(99) < full_pct);
            kc_buffer_full = fl;
            pend = kc_in_ready && fl;
            pw = cur;
            if (kc_in_ready && !fl) begin
                obs_q.push_back(cur);
                xcyc.push_back(cyc);
            end
            if (idx < msg.size() && $urandom_range(99) < valid_pct) begin
                byte_valid = 1'b1;
                byte_in = msg[idx];
                byte_last = (idx == msg.size() - 1);
                if (byte_ready) idx++;
            end else begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                byte_last = 1'($urandom);
            end
        end
        byte_valid = 1'b0;
        byte_last = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d want %0d (timeout)", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d: got w=%h last=%b bn=%0d want w=%h last=%b bn=%0d",
                         name, i, obs_q[i].w, obs_q[i].last, obs_q[i].bn, exp_q[i].w, exp_q[i].last, exp_q[i].bn);
            end
        end
    endtask

    // Checks the digest wait (bytes blocked, length held) and the release.
    task automatic finish_msg(input string name, input int n);
        logic [LW-1:0] el;
        el = LW'((n > 15) ? 15 : n);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b0 || kc_in_ready !== 1'b0 || busy !== 1'b1 || msg_len !== el) begin
                errors++;
                $display("FAIL %s wait_digest: got brdy=%b krdy=%b busy=%b len=%0d want 0 0 1 %0d",
                         name, byte_ready, kc_in_ready, busy, msg_len, el);
            end
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
            byte_last = 1'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last = 1'b0;
        kc_out_ready = 1'b1;
        @(negedge clk);
        kc_out_ready = 1'b0;
        checks++;
        if (byte_ready !== 1'b1 || msg_len !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got brdy=%b len=%0d busy=%b want 1 0 0", name, byte_ready, msg_len, busy);
        end
    endtask

    task automatic feed_bytes(input string s, input int n);
        int idx;
        int budget;
        idx = 0; budget = 0;
        while (idx < n && budget < 100) begin
            @(negedge clk);
            budget++;
            byte_valid = 1'b1;
            byte_in = s[idx];
            byte_last = 1'b0;
            if (byte_ready) idx++;
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL feed: got %0d bytes want %0d", idx, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (kc_in !== 32'd0 || kc_in_ready !== 1'b0 || kc_is_last !== 1'b0 || kc_byte_num !== 2'd0 ||
            msg_len !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got w=%h rdy=%b last=%b bn=%0d len=%0d busy=%b want all 0",
                     kc_in, kc_in_ready, kc_is_last, kc_byte_num, msg_len, busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1 || kc_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got brdy=%b krdy=%b want 1 0", byte_ready, kc_in_ready);
        end
    endtask

    task automatic test_hello13();
        full_pct = 0; valid_pct = 100;
        load("Hello, world!");
        send_msg("hello13");
        checks++;
        if (obs_q.size() != 4 || obs_q[0].w !== 32'h48656C6C || obs_q[3] !== {32'h21000000, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL hello13_literal: got n=%0d w0=%h w3=%h want 4 48656c6c 21000000/last/1",
                     obs_q.size(), obs_q[0].w, obs_q[3].w);
        end
        checks++;
        if (xcyc.size() == 4 && (xcyc[1] - xcyc[0] != 5 || xcyc[2] - xcyc[1] != 5)) begin
            errors++;
            $display("FAIL word_rate: got %0d,%0d cycles want 5,5", xcyc[1] - xcyc[0], xcyc[2] - xcyc[1]);
        end
        finish_msg("hello13", 13);
    endtask

    task automatic test_hello12_pad();
        full_pct = 0; valid_pct = 100;
        load("Hello, world");
        send_msg("hello12");
        checks++;
        if (xcyc.size() != 4 || xcyc[3] - xcyc[2] != 1) begin
            errors++;
            $display("FAIL pad_timing: got n=%0d gap=%0d want 4 words gap 1", xcyc.size(),
                     (xcyc.size() == 4) ? xcyc[3] - xcyc[2] : -1);
        end
        finish_msg("hello12", 12);
    endtask

    task automatic test_backpressure();
        full_pct = 0; valid_pct = 100;
        kc_buffer_full = 1'b1;
        feed_bytes("Hell", 4);
        repeat (7) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in = 8'h6F;
            byte_last = 1'b1;
            checks++;
            if (kc_in_ready !== 1'b1 || kc_in !== 32'h48656C6C || byte_ready !== 1'b0 || msg_len !== LW'(4)) begin
                errors++;
                $display("FAIL backpressure_hold: got rdy=%b w=%h brdy=%b len=%0d want 1 48656c6c 0 4",
                         kc_in_ready, kc_in, byte_ready, msg_len);
            end
        end
        kc_buffer_full = 1'b0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        @(negedge clk);
        checks++;
        if (kc_in_ready !== 1'b0 || byte_ready !== 1'b1 || msg_len !== LW'(4)) begin
            errors++;
            $display("FAIL backpressure_release: got krdy=%b brdy=%b len=%0d want 0 1 4", kc_in_ready, byte_ready, msg_len);
        end
        load("o");
        send_msg("bp_tail");
        finish_msg("bp_tail", 5);
    endtask

    task automatic test_single();
        full_pct = 0; valid_pct = 100;
        load("a");
        send_msg("single");
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {32'h61000000, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL single_literal: got n=%0d w=%h want 1 61000000", obs_q.size(), obs_q[0].w);
        end
        finish_msg("single", 1);
    endtask

    task automatic test_reset_mid();
        kc_buffer_full = 1'b0;
        feed_bytes("The quick", 6);
        @(negedge clk);
        byte_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (kc_in !== 32'd0 || kc_in_ready !== 1'b0 || msg_len !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got w=%h rdy=%b len=%0d busy=%b want 0 0 0 0", kc_in, kc_in_ready, msg_len, busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1 || kc_in_ready !== 1'b0 || msg_len !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got brdy=%b krdy=%b len=%0d busy=%b want 1 0 0 0",
                     byte_ready, kc_in_ready, msg_len, busy);
        end
        full_pct = 0; valid_pct = 100;
        load("dog ");
        send_msg("dog");
        checks++;
        if (obs_q.size() != 2 || obs_q[0].w !== 32'h646F6720 || obs_q[1] !== {32'd0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL dog_literal: got n=%0d w0=%h w1=%h want 2 646f6720 00000000", obs_q.size(), obs_q[0].w, obs_q[1].w);
        end
        finish_msg("dog", 4);
    endtask

    task automatic test_saturation();
        full_pct = 20; valid_pct = 80;
        load_random(19);
        send_msg("saturate");
        finish_msg("saturate", 19);
    endtask

    task automatic test_random();
        for (int m = 0; m < 8; m++) begin
            int n;
            n = $urandom_range(22, 1);
            full_pct = $urandom_range(50);
            valid_pct = $urandom_range(100, 40);
            load_random(n);
            send_msg("random");
            finish_msg("random", n);
        end
    endtask

    initial begin
        test_reset();
        test_hello13();
        test_hello12_pad();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_byte_packer.md
Name: sha3_byte_packer

Overview:
- Upstream feeder for the keccak core. It takes a byte stream with valid/ready/last handshakes and packs it into the core's 32-bit word interface.
- Drives the core's `in`, `in_ready`, `is_last` and `byte_num` inputs, and obeys the core's `buffer_full` backpressure.
- Generates the zero-length terminator word that the core needs when the message length is a multiple of 4.
- Blocks new bytes from the end of one message until the core reports the digest.

Parameters:
- LEN_W, 16, width of the message byte counter `msg_len`; the counter saturates at all-ones.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- byte_in  in  8  message byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  byte_in is the final byte of the message; qualified by byte_valid.
- byte_ready  out  1  packer accepts a byte this cycle.
- kc_in  out  32  word to the core's `in`; first byte in [31:24], unused low bytes 0.
- kc_in_ready  out  1  word valid, to the core's `in_ready`.
- kc_is_last  out  1  to the core's `is_last`.
- kc_byte_num  out  2  to the core's `byte_num`: count of valid bytes in the final word.
- kc_buffer_full  in  1  the core's `buffer_full`.
- kc_out_ready  in  1  the core's `out_ready` (digest available).
- msg_len  out  LEN_W  bytes accepted in the current message.
- busy  out  1  high in any state except FILL with cnt=0.

Behaviour:
- Byte transfer: occurs at a rising edge with byte_valid & byte_ready. byte_ready = (state==FILL), combinational from state only.
- Word transfer: occurs at a rising edge with kc_in_ready & !kc_buffer_full.
  - kc_in, kc_is_last and kc_byte_num stay stable from kc_in_ready rising until the transfer.
  - kc_in_ready drops on the cycle after the transfer, unless another word is due.
- States: FILL, SEND, SEND_LAST, SEND_PAD, WAIT_DIGEST.
- FILL: byte counter cnt (0..3). The accepted byte is written into lane [31-8*cnt -: 8] of the word register.
  - byte accepted, byte_last=0, cnt<3: cnt+1.
  - byte accepted, byte_last=0, cnt==3: go to SEND, cnt=0.
  - byte accepted, byte_last=1, cnt==3: go to SEND then SEND_PAD (flag pad_pending=1).
  - byte accepted, byte_last=1, cnt<3: go to SEND_LAST with kc_byte_num=cnt+1, cnt=0.
- SEND: kc_in_ready=1, kc_is_last=0, kc_byte_num=0. On transfer:
  - clear the word register;
  - go to SEND_PAD if pad_pending, else FILL.
- SEND_LAST: kc_in_ready=1, kc_is_last=1, kc_byte_num=1..3. On transfer go to WAIT_DIGEST.
- SEND_PAD: kc_in=0, kc_in_ready=1, kc_is_last=1, kc_byte_num=0. On transfer go to WAIT_DIGEST and clear pad_pending.
- WAIT_DIGEST: kc_in_ready=0, byte_ready=0. When kc_out_ready=1 at an edge: go to FILL, reset msg_len to 0.
- Latency: the byte that completes a word makes kc_in_ready high in the next cycle.
  - Minimum 5 cycles per word with no backpressure: 4 byte cycles + 1 send cycle.
  - The terminator word follows 1 cycle after the last full word transfers.
- msg_len: increments on each byte transfer and saturates at 2^LEN_W-1. It holds its value in WAIT_DIGEST.
- Backpressure: kc_buffer_full may stay high indefinitely. The packer holds the word and does not accept bytes.
- byte_last with byte_valid=0: ignored.
- reset_n low at any time, including mid-word or mid-send:
  - state=FILL, cnt=0, word register=0, pad_pending=0, msg_len=0;
  - all outputs 0 except byte_ready=1 once reset_n deasserts.
  - The core is reset separately by its owner.
- Reset values: kc_in=0, kc_in_ready=0, kc_is_last=0, kc_byte_num=0, byte_ready=1 (combinational from FILL), msg_len=0, busy=0.

Test Plan:
- "Hello, world!" (13 bytes, last on '!'), kc_buffer_full=0
  -> words 0x48656C6C, 0x6F2C2077, 0x6F726C64 with is_last=0;
  -> then 0x21000000 with is_last=1, byte_num=1;
  -> WAIT_DIGEST, msg_len=13.
- "Hello, world" (12 bytes)
  -> three full words;
  -> then, one cycle after the third word transfers, 0x00000000 with is_last=1, byte_num=0;
  -> msg_len=12.
- kc_buffer_full=1 for 7 cycles while the word "Hell" is pending
  -> kc_in stays 0x48656C6C with kc_in_ready=1 throughout;
  -> byte_ready=0 and no bytes consumed;
  -> transfer on the first edge with kc_buffer_full=0.
- Single byte 'a' with byte_last=1
  -> 0x61000000, is_last=1, byte_num=1;
  -> bytes offered afterwards are rejected (byte_ready=0) until a kc_out_ready pulse, after which byte_ready=1 and msg_len=0.
- reset_n pulsed low after 6 bytes of "The quick"
  -> on deassertion: kc_in_ready=0, msg_len=0, cnt=0;
  -> then "dog " as a full message gives word 0x646F6720 followed by a pad word with is_last=1, byte_num=0.
